alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
Parametrised successor to the per-thread ALU. It provides ADD/SUB/MUL single-cycle ops and a compare op that produces {gt,eq,lt} flags. DIV is an iterative restoring divider running over DATA_WIDTH cycles. A start/busy/done handshake lets the core scheduler stall in EXECUTE until the result is valid; one instance sits in each thread lane of a core.

Parameters:
DATA_WIDTH, 8, operand/result width in bits (>=2)
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  lane enable; low = block frozen (all state holds, start ignored)
alu_start  input  1  single-cycle request; sampled only in IDLE with enable=1
decoded_alu_arithmetic_mux  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
decoded_alu_output_mux  input  1  1 = compare op (overrides arithmetic mux)
rs  input  DATA_WIDTH  operand A, sampled with alu_start
rt  input  DATA_WIDTH  operand B, sampled with alu_start
alu_out  output  DATA_WIDTH  registered result; holds until next completion
alu_busy  output  1  high while an operation is in flight (DIV_RUN)
alu_done  output  1  one-cycle pulse: alu_out updated this cycle

Behaviour:
- Interface: reset is synchronous, active-high, named reset; clock is clk.
- Reset: state=IDLE, alu_out=0, alu_busy=0, alu_done=0, counter=0, internal remainder/quotient/divisor=0.
- States: IDLE, DIV_RUN. The done pulse is a registered flag, not a state.
- IDLE, enable=1, alu_start=1 (edge N):
  - compare: alu_out <= {0..., gt, eq, lt}, with bit2=gt, bit1=eq, bit0=lt; unsigned compare; exactly one flag set. alu_done=1 in cycle after edge N. Latency 1.
  - ADD/SUB: alu_out <= (rs +/- rt) mod 2^DATA_WIDTH, wrap-around, no carry out. Latency 1.
  - MUL: alu_out <= low DATA_WIDTH bits of the full product. Latency 1.
  - DIV: latch dividend=rs, divisor=rt; remainder=0; counter=0; go DIV_RUN; alu_busy=1 after edge N.
- DIV_RUN, enable=1: each edge performs one restoring step, MSB first:
  - rem' = {rem, dividend MSB} - divisor, if non-negative; set quotient bit, else restore.
  - Shift dividend left; counter++.
  - On the edge where counter reaches DATA_WIDTH (edge N+DATA_WIDTH): alu_out <= quotient, alu_busy <= 0, alu_done pulses, go IDLE. DIV latency = DATA_WIDTH cycles.
- Divide by zero: no special state; the algorithm yields quotient = all ones (2^DATA_WIDTH-1) with normal latency. This is required behaviour.
- alu_start while busy: ignored; operands unchanged; no error.
- alu_start in IDLE with start and completion in the same cycle is impossible (busy blocks start); back-to-back single-cycle ops are allowed every cycle, with alu_done high each cycle.
- enable=0 mid-DIV: counter, remainder and quotient freeze; resume on enable=1 with no step lost. alu_done is forced 0 while enable=0.
- Reset mid-DIV: immediate return to IDLE, alu_out=0; no done pulse.
- alu_done is high for exactly one enabled cycle per accepted start.

Optional Feature:
Macro: ALU_SIGNED_CMP_EN.
- Defined: the compare op treats rs/rt as two's complement (e.g. rs=0xFF, rt=0x01 gives lt=1). ADD/SUB/MUL/DIV are unchanged and remain unsigned.
- Undefined: the compare op is unsigned only (rs=0xFF, rt=0x01 gives gt=1).
- No port or latency change either way.

Test Plan:
- DATA_WIDTH=8; ADD rs=0xF0, rt=0x20 -> next cycle alu_out=0x10, alu_done=1 for one cycle, alu_busy=0.
- MUL rs=0x13, rt=0x11 -> alu_out=0x43 (0x143 truncated). SUB rs=0x03, rt=0x05 -> alu_out=0xFE.
- DIV rs=200, rt=7 -> alu_busy high 8 cycles; alu_done exactly 8 cycles after start edge; alu_out=28. A start asserted during busy (rs=1, rt=1) is ignored and the result is still 28.
- DIV rs=0x55, rt=0 -> alu_out=0xFF after 8 cycles. Then DIV with enable dropped for 3 cycles mid-run -> done at 11 cycles, correct quotient.
- Compare rs=5, rt=5 -> alu_out=0x02; rs=0xFF, rt=0x01 -> 0x04 without ALU_SIGNED_CMP_EN, 0x01 with it.
- Reset asserted at DIV iteration 4 -> next cycle alu_out=0, alu_busy=0, no alu_done pulse; a subsequent ADD 1+1 yields 0x02 normally.

Source files
------------

// File: rtl/alu_multicycle.sv
// Per-lane ALU: single-cycle ADD/SUB/MUL/compare and a DATA_WIDTH-cycle restoring divider.
// Define ALU_SIGNED_CMP_EN to make the compare op two's complement (arithmetic stays unsigned).
module alu_multicycle #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  alu_start,
    input  logic [1:0]            decoded_alu_arithmetic_mux,
    input  logic                  decoded_alu_output_mux,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  alu_busy,
    output logic                  alu_done
);

    typedef enum logic {StIdle, StDivRun} state_e;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;

    logic [DATA_WIDTH+1:0] trial;
    logic                  trial_neg;
    logic [DATA_WIDTH-1:0] quo_step;
    logic                  gt, eq, lt;

    always_comb begin
`ifdef ALU_SIGNED_CMP_EN
        gt = $signed(rs) > $signed(rt);
        lt = $signed(rs) < $signed(rt);
`else
        gt = rs > rt;
        lt = rs < rt;
`endif
        eq = rs == rt;
    end

    // Extra top bit of trial is the sign of {rem, next dividend bit} - divisor.
    assign trial     = {1'b0, rem_q, dvd_q[DATA_WIDTH-1]} - {2'b00, dvs_q};
    assign trial_neg = trial[DATA_WIDTH+1];
    assign quo_step  = {quo_q[DATA_WIDTH-2:0], ~trial_neg};

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;

        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (alu_start) begin
                        if (decoded_alu_output_mux) begin
                            out_d  = DATA_WIDTH'({gt, eq, lt});
                            done_d = 1'b1;
                        end else begin
                            unique case (decoded_alu_arithmetic_mux)
                                OpAdd: begin
                                    out_d  = rs + rt;
                                    done_d = 1'b1;
                                end
                                OpSub: begin
                                    out_d  = rs - rt;
                                    done_d = 1'b1;
                                end
                                OpMul: begin
                                    out_d  = rs * rt;
                                    done_d = 1'b1;
                                end
                                OpDiv: begin
                                    dvd_d   = rs;
                                    dvs_d   = rt;
                                    rem_d   = '0;
                                    quo_d   = '0;
                                    cnt_d   = '0;
                                    state_d = StDivRun;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StDivRun: begin
                    // Divide by zero never restores, so the quotient fills with ones.
                    if (trial_neg) begin
                        rem_d = {rem_q[DATA_WIDTH-2:0], dvd_q[DATA_WIDTH-1]};
                    end else begin
                        rem_d = trial[DATA_WIDTH-1:0];
                    end
                    quo_d = quo_step;
                    dvd_d = {dvd_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        out_d   = quo_step;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            out_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
        end
    end

    assign alu_out  = out_q;
    assign alu_busy = (state_q == StDivRun);
    assign alu_done = done_q & enable;

endmodule
